// File: rtl/de0_nano_nios2_trace_capture_buffer.sv
// Circular trace capture RAM with arm/trigger/post-trigger control and
// registered debug-side readout for the JTAG debug slave.
module de0_nano_nios2_trace_capture_buffer #(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DATA_W    = 36,
    parameter int unsigned POST_TRIG = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trc_valid,
    input  logic [DATA_W-1:0] trc_data,
    input  logic              trigger_in,
    input  logic              ctrl_load,
    input  logic [2:0]        ctrl_word,
    input  logic              rd_load,
    input  logic              rd_next,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] tracemem_trcdata,
    output logic              tracemem_tw,
    output logic              tracemem_on,
    output logic              trc_on,
    output logic [ADDR_W-1:0] trc_im_addr,
    output logic              trc_wrap,
    output logic              trc_done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wrap_q, wrap_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem_q [0:DEPTH-1];

    logic arm, clr, stop, we;

    assign arm     = ctrl_load & ctrl_word[0];
    assign clr     = ctrl_load & ctrl_word[1];
    assign stop    = ctrl_load & ctrl_word[2];
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wrap_d  = wrap_q;
        cnt_d   = cnt_q;
        // A clear or stop in the same cycle drops the incoming word.
        we = trc_valid && !reset && !clr && !stop &&
             (state_q == ARMED || state_q == POST);

        if (we) begin
            addr_d = addr_q + ADDR_W'(1);
            if (addr_q == '1)
                wrap_d = 1'b1;
        end

        if (clr) begin
            addr_d = '0;
            wrap_d = 1'b0;
            cnt_d  = '0;
        end

        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (arm) state_d = ARMED;
                ARMED: if (trigger_in) begin
                    state_d = POST;
                    cnt_d   = '0;
                end
                POST:  if (we) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(POST_TRIG))
                        state_d = DONE;
                end
                DONE:  if (arm) state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (rd_load)
            rd_ptr_d = rd_addr;
        else if (rd_next)
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wrap_q   <= 1'b0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wrap_q   <= wrap_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            rdata_q  <= mem_q[rd_ptr_q];
        end
    end

    // RAM is not reset; read-before-write falls out of the registered read.
    always_ff @(posedge clk) begin
        if (we)
            mem_q[addr_q] <= trc_data;
    end

    assign tracemem_trcdata = rdata_q;
    assign tracemem_tw      = rdata_q[DATA_W-1];
    assign tracemem_on      = (state_q == ARMED) || (state_q == POST);
    assign trc_on           = tracemem_on;
    assign trc_im_addr      = addr_q;
    assign trc_wrap         = wrap_q;
    assign trc_done         = (state_q == DONE);

endmodule
